// File: rtl/dspl_scan_drv.sv
// ---------------------------------------------------------------------------
// dspl_scan_drv
//   Drives an 8-digit multiplexed 7-segment display from eight 6-bit digit
//   words. One anode is active at a time (active-low). Each digit slot starts
//   with a short all-dark gap to suppress ghosting. All eight words are
//   captured together once per frame, so one scan never mixes old and new
//   values.
//
// Parameters
//   SCAN_DIV      clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  leading dark cycles of each slot (1 .. SCAN_DIV-1)
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous, active-low reset
//   d1..d8       in   digit word {en, bcd[3:0], dp_n}; d1 rightmost, d8 leftmost
//   an           out  anode enables, active-low; an[k] selects d(k+1)
//   dec_cat      out  cathodes, active-low, {a,b,c,d,e,f,g,dp}
//   frame_start  out  one-cycle pulse on the snapshot cycle (slot 0, cnt 0)
// ---------------------------------------------------------------------------
module dspl_scan_drv #(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] dec_cat,
    output logic       frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      idx_reg;
    logic [7:0][5:0] d_arr;
    logic [7:0][5:0] snap_reg;
    logic [7:0]      an_reg, an_next;
    logic [7:0]      dec_reg, dec_next;
    logic [5:0]      cur_word;
    logic            frame_tick;

    // Index 0 is the rightmost digit, matching an[0].
    assign d_arr = {d8, d7, d6, d5, d4, d3, d2, d1};

    assign frame_tick = (cnt_reg == '0) && (idx_reg == 3'd0);

    // The snapshot cycle coincides with the reset state of the counters, so
    // the pulse is qualified by the reset pin to stay low while reset is held
    // and to fire on the very first cycle after release.
    assign frame_start = reset & frame_tick;

    assign an      = an_reg;
    assign dec_cat = dec_reg;

    // Active-low {a,b,c,d,e,f,g}; non-decimal codes are dark.
    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Slot timing: cnt runs through one slot, idx steps through the 8 digits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            idx_reg <= 3'd0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + 3'd1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Frame snapshot: all eight words captured together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_reg <= '0;
        end else if (frame_tick) begin
            snap_reg <= d_arr;
        end
    end

    // FSM state and registered display outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_BLANK;
            an_reg    <= 8'hFF;
            dec_reg   <= 8'hFF;
        end else begin
            state_reg <= state_next;
            an_reg    <= an_next;
            dec_reg   <= dec_next;
        end
    end

    assign cur_word = snap_reg[idx_reg];

    always_comb begin
        state_next = state_reg;
        an_next    = 8'hFF;
        dec_next   = 8'hFF;
        case (state_reg)
            ST_BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // A disabled digit stays fully dark, decimal point included.
                if (cur_word[5]) begin
                    an_next  = ~(8'b1 << idx_reg);
                    dec_next = {seg7(cur_word[4:1]), cur_word[0]};
                end
                // The last SHOW cycle hands over to the next slot's gap, so
                // the registered anodes go all-high before the next digit.
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_BLANK;
                end
            end
            default: state_next = ST_BLANK;
        endcase
    end

endmodule

// File: tb/tb_dspl_scan_drv.sv
// Randomized scoreboard bench for dspl_scan_drv (SCAN_DIV=8, BLANK_CYCLES=2).
// The driver applies inputs each cycle and pushes the expected outputs for
// that cycle, computed from the frame/slot position; the monitor pops and
// compares on the falling edge.
module tb_dspl_scan_drv;

    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 8 * SD;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] dec;
        logic       fs;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] din   [8];
    logic [5:0] msnap [8];
    logic [7:0] an;
    logic [7:0] dec_cat;
    logic       frame_start;

    exp_t q[$];
    int   t;
    bit   in_reset;
    int   vectors;
    int   miscompares;
    bit   done;

    dspl_scan_drv #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clock       (clk),
        .reset       (rst_n),
        .d1          (din[0]),
        .d2          (din[1]),
        .d3          (din[2]),
        .d4          (din[3]),
        .d5          (din[4]),
        .d6          (din[5]),
        .d7          (din[6]),
        .d8          (din[7]),
        .an          (an),
        .dec_cat     (dec_cat),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference segment table, active-low {a..g}.
    function automatic logic [6:0] seg_ref(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected outputs for the current cycle. Display outputs show the
    // position of the previous cycle; the pulse marks the start of a frame.
    task automatic push_expect();
        exp_t e;
        e.an  = 8'hFF;
        e.dec = 8'hFF;
        e.fs  = 1'b0;
        if (!in_reset) begin
            e.fs = ((t % FRAME) == 0);
            if (t >= 1) begin
                int p;
                int slot;
                int c;
                logic [5:0] w;
                p    = (t - 1) % FRAME;
                slot = p / SD;
                c    = p % SD;
                w    = msnap[slot];
                if (c >= BL && w[5]) begin
                    e.an  = ~(8'd1 << slot);
                    e.dec = {seg_ref(int'(w[4:1])), w[0]};
                end
            end
            if ((t % FRAME) == 0) begin
                for (int i = 0; i < 8; i++) msnap[i] = din[i];
            end
            t++;
        end
        q.push_back(e);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            push_expect();
        end
    endtask

    task automatic rand_cycle();
        @(posedge clk);
        #1;
        if ($urandom_range(0, 5) == 0) begin
            din[$urandom_range(0, 7)] = 6'($urandom);
        end
        push_expect();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        t        = 0;
        push_expect();
    endtask

    // Monitor: one comparison set per expected entry.
    initial begin
        vectors     = 0;
        miscompares = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                vectors++;
                if (an !== e.an) begin
                    miscompares++;
                    $display("FAIL an t=%0d got=%h exp=%h", t - 1, an, e.an);
                end
                if (dec_cat !== e.dec) begin
                    miscompares++;
                    $display("FAIL dec_cat t=%0d got=%h exp=%h", t - 1, dec_cat, e.dec);
                end
                if (frame_start !== e.fs) begin
                    miscompares++;
                    $display("FAIL frame_start t=%0d got=%b exp=%b", t - 1, frame_start, e.fs);
                end
                if ($countones(~an) > 1) begin
                    miscompares++;
                    $display("FAIL multi_anode t=%0d got=%h exp=<=1 low", t - 1, an);
                end
                $display("vec %0d rst=%b an=%h dec=%h fs=%b", vectors, rst_n, an, dec_cat, frame_start);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        done     = 1'b0;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        t        = 0;
        for (int i = 0; i < 8; i++) begin
            din[i]   = 6'h3F;
            msnap[i] = 6'h00;
        end

        // Reset held with all inputs high.
        run_cycles(4);

        // Frame 0: digit k shows k in slot k.
        for (int k = 0; k < 8; k++) din[k] = {1'b1, 4'(k), 1'b1};
        release_reset();
        run_cycles(FRAME - 1);

        // Frame 1: '8' with dp off in slot 0, '8' with dp on in slot 7.
        @(posedge clk);
        #1;
        din[0] = 6'h31;
        din[7] = 6'h30;
        push_expect();
        run_cycles(FRAME - 1);

        // Frame 2: d1=5, d5 disabled, d4=12 (dark segments, anode active);
        // d1 changes to 9 during slot 3 and must wait for the next frame.
        @(posedge clk);
        #1;
        din[0] = {1'b1, 4'd5, 1'b1};
        din[4] = {1'b0, 4'd5, 1'b1};
        din[3] = {1'b1, 4'd12, 1'b1};
        push_expect();
        run_cycles(3 * SD + 1);
        @(posedge clk);
        #1;
        din[0] = {1'b1, 4'd9, 1'b1};
        push_expect();
        run_cycles(FRAME - 3 * SD - 3);
        run_cycles(FRAME);

        // Random frames.
        for (int i = 0; i < 6 * FRAME; i++) rand_cycle();

        // Reset in the middle of slot 5's SHOW phase.
        din[5] = {1'b1, 4'd6, 1'b0};
        while ((t % FRAME) != 0) rand_cycle();
        while ((t % FRAME) != 5 * SD + 4) rand_cycle();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        push_expect();
        run_cycles(3);
        release_reset();
        for (int i = 0; i < 2 * FRAME; i++) rand_cycle();

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
